// File: rtl/monitor_tester_pkg.sv
// Shared definitions for the monitor tester pattern sequencing logic.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
//
// Contents: default mode count/width, scheduler FSM state enum, and the
// 1-based modular add used to step through pattern modes.
package monitor_tester_pkg;

  localparam int NUM_MODES = 7;
  localparam int MODE_W    = 5;

  typedef enum logic [1:0] {
    MANUAL   = 2'd0,
    AUTO     = 2'd1,
    OVERRIDE = 2'd2
  } sched_state_e;

  // 1-based modular add: maps base+delta into 1..n.
  // The 4*n bias keeps the dividend non-negative for |delta| <= 3,
  // so the remainder never comes out negative.
  function automatic int wrap_mode(input int base, input int delta, input int n);
    int t;
    t = base - 1 + delta + 4 * n;
    return (t % n) + 1;
  endfunction

endpackage

// File: rtl/switch_override_decode.sv
// Switch override decode: one-hot check on the switch bank, bit index -> mode.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the result is consumed only at frame boundaries.
//
// Ports:
//   switches  in   10      raw override switch bank
//   ovReq     out  1       exactly one bit set, and that bit maps to a valid mode
//   ovMode    out  MODE_W  requested mode (bit k -> mode k+1), 0 when ovReq=0
module switch_override_decode
  import monitor_tester_pkg::*;
#(
  parameter int NUM_MODES = monitor_tester_pkg::NUM_MODES,
  parameter int MODE_W    = monitor_tester_pkg::MODE_W
) (
  input  logic [9:0]        switches,
  output logic              ovReq,
  output logic [MODE_W-1:0] ovMode
);

  logic one_hot;

  // x & (x-1) clears the lowest set bit; zero afterwards means at most one bit.
  assign one_hot = (switches != 10'd0) && ((switches & (switches - 10'd1)) == 10'd0);

  always_comb begin
    ovReq  = 1'b0;
    ovMode = '0;
    for (int k = 0; k < 10; k++) begin
      // Bits at or above NUM_MODES have no pattern behind them: no override.
      if (one_hot && switches[k] && (k < NUM_MODES)) begin
        ovReq  = 1'b1;
        ovMode = MODE_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/pattern_mode_scheduler.sv
// Pattern mode scheduler: buttons, switch override and auto-cycle -> displayed mode.
// Latency: outputs update on the clock edge that samples frameStart; valid next cycle.
// Backpressure: none; presses between frames accumulate in a saturating +/-3 delta.
//
// Ports:
//   clock25MHz      in   1       pixel clock
//   resetN          in   1       synchronous active-low reset
//   nextPressed     in   1       one-cycle pulse, step forward
//   prevPressed     in   1       one-cycle pulse, step backward
//   switches        in   10      override bank (one-hot selects a mode)
//   frameStart      in   1       one-cycle pulse at start of vertical blank
//   autoEnable      in   1       level, enables auto-cycle
//   displayMode     out  MODE_W  registered mode for the pattern mux
//   modeChanged     out  1       pulse in the cycle displayMode takes a new value
//   overrideActive  out  1       registered, high while a switch override is shown
module pattern_mode_scheduler
  import monitor_tester_pkg::*;
#(
  parameter int NUM_MODES   = monitor_tester_pkg::NUM_MODES,
  parameter int MODE_W      = monitor_tester_pkg::MODE_W,
  parameter int AUTO_FRAMES = 300,
  parameter int CNT_W       = 9
) (
  input  logic              clock25MHz,
  input  logic              resetN,
  input  logic              nextPressed,
  input  logic              prevPressed,
  input  logic [9:0]        switches,
  input  logic              frameStart,
  input  logic              autoEnable,
  output logic [MODE_W-1:0] displayMode,
  output logic              modeChanged,
  output logic              overrideActive
);

  localparam logic signed [2:0] PEND_MAX = 3'sd3;
  localparam logic signed [2:0] PEND_MIN = -3'sd3;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(AUTO_FRAMES - 1);

  // State and registered outputs
  sched_state_e       state_q, state_d;
  logic [MODE_W-1:0]  base_q, base_d;
  logic signed [2:0]  pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [MODE_W-1:0]  disp_q, disp_d;
  logic               chg_q, chg_d;
  logic               ovr_q, ovr_d;

  // Override decode
  logic               ov_req;
  logic [MODE_W-1:0]  ov_mode;

  switch_override_decode #(
    .NUM_MODES (NUM_MODES),
    .MODE_W    (MODE_W)
  ) u_ov_decode (
    .switches (switches),
    .ovReq    (ov_req),
    .ovMode   (ov_mode)
  );

  // Net button request this cycle; simultaneous next+prev cancel out.
  logic signed [2:0] press_delta;
  logic signed [2:0] pend_sat;

  always_comb begin
    press_delta = 3'sd0;
    if (nextPressed && !prevPressed) begin
      press_delta = 3'sd1;
    end else if (prevPressed && !nextPressed) begin
      press_delta = -3'sd1;
    end
  end

  // Saturating accumulate: presses beyond +/-3 in one frame are dropped.
  always_comb begin
    pend_sat = pend_q;
    if ((press_delta == 3'sd1) && (pend_q != PEND_MAX)) begin
      pend_sat = pend_q + 3'sd1;
    end else if ((press_delta == -3'sd1) && (pend_q != PEND_MIN)) begin
      pend_sat = pend_q - 3'sd1;
    end
  end

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    pend_d  = pend_sat;
    cnt_d   = cnt_q;
    disp_d  = disp_q;
    chg_d   = 1'b0;
    ovr_d   = ovr_q;

    if (frameStart) begin
      if (ov_req) begin
        state_d = OVERRIDE;
      end else if (autoEnable) begin
        state_d = AUTO;
      end else begin
        state_d = MANUAL;
      end

      // A press coinciding with frameStart belongs to the next frame.
      pend_d = press_delta;

      if (pend_q != 3'sd0) begin
        // Manual step applies in every state and restarts the auto dwell.
        base_d = MODE_W'(wrap_mode(int'(base_q), int'(pend_q), NUM_MODES));
        cnt_d  = '0;
      end else if (state_d == AUTO) begin
        if (cnt_q == CNT_LAST) begin
          base_d = MODE_W'(wrap_mode(int'(base_q), 1, NUM_MODES));
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end else begin
        cnt_d = '0;
      end

      disp_d = (state_d == OVERRIDE) ? ov_mode : base_d;
      chg_d  = (disp_d != disp_q);
      ovr_d  = (state_d == OVERRIDE);
    end
  end

  always_ff @(posedge clock25MHz) begin
    if (!resetN) begin
      state_q <= MANUAL;
      base_q  <= MODE_W'(1);
      pend_q  <= 3'sd0;
      cnt_q   <= '0;
      disp_q  <= MODE_W'(1);
      chg_q   <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      pend_q  <= pend_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      chg_q   <= chg_d;
      ovr_q   <= ovr_d;
    end
  end

  assign displayMode    = disp_q;
  assign modeChanged    = chg_q;
  assign overrideActive = ovr_q;

endmodule
